// File: rtl/apu_result_queue_if.sv
// Bundle of the decoder-side result push, the writeback hold and the
// APU response signals of the result-return stage.
interface apu_result_queue_if #(
    parameter int VLEN  = 128,
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int VL_W  = $clog2(VLEN / 8) + 1,
    parameter int IDX_W = $clog2(VLEN / 8),
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    // Request side: one result committed by the decoder
    logic             push_i;
    logic [1:0]       src_i;
    logic [VL_W-1:0]  vl_i;
    logic [1:0]       vsew_i;
    logic [IDX_W-1:0] elem_idx_i;
    logic             sign_ext_i;
    logic [VLEN-1:0]  vs2_data_i;
    logic [XLEN-1:0]  scalar_i;
    logic [4:0]       flags_i;
    logic             hold_i;

    // Response side: result pulses and queue status
    logic             apu_rvalid_o;
    logic [XLEN-1:0]  apu_result_o;
    logic [4:0]       apu_flags_o;
    logic             full_o;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;

    // Decoder/core side
    modport master (
        output push_i, src_i, vl_i, vsew_i, elem_idx_i, sign_ext_i,
               vs2_data_i, scalar_i, flags_i, hold_i,
        input  apu_rvalid_o, apu_result_o, apu_flags_o, full_o,
               count_o, overflow_o
    );

    // Result queue side
    modport slave (
        input  push_i, src_i, vl_i, vsew_i, elem_idx_i, sign_ext_i,
               vs2_data_i, scalar_i, flags_i, hold_i,
        output apu_rvalid_o, apu_result_o, apu_flags_o, full_o,
               count_o, overflow_o
    );
endinterface

// File: rtl/apu_result_queue.sv
// Result-return stage: forms one scalar result per completing instruction,
// queues it in an in-order FIFO and returns it to the core as a single-cycle
// apu_rvalid pulse. An empty queue with no hold bypasses straight to the
// output registers; pushes into a full queue are dropped and flagged.
module apu_result_queue #(
    parameter int VLEN  = 128,
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int VL_W  = $clog2(VLEN / 8) + 1,
    parameter int IDX_W = $clog2(VLEN / 8)
) (
    input  logic                 clk,
    input  logic                 reset,
    apu_result_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Bit offset of an element: index times up to 32 bits, plus headroom
    // so the out-of-range comparison never wraps.
    localparam int OFF_W = IDX_W + 6;
    localparam logic [OFF_W-1:0] VLEN_BITS  = OFF_W'(VLEN);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        SRC_VL     = 2'd0,
        SRC_ELEM   = 2'd1,
        SRC_SCALAR = 2'd2,
        SRC_ZERO   = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        SEW_8   = 2'd0,
        SEW_16  = 2'd1,
        SEW_32  = 2'd2,
        SEW_RSV = 2'd3
    } sew_e;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      flags;
    } entry_t;

    // Result formation
    logic [OFF_W-1:0] bit_off;
    logic [31:0]      elem_bits;
    logic             elem_ok;
    logic [XLEN-1:0]  elem;
    entry_t           formed;

    // Queue storage and control
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic             full;
    logic             pop;
    logic             bypass;
    logic             wr_en;
    logic             drop;

    // Output registers
    logic             rvalid_r;
    entry_t           out_r;

    // Element extraction: locate the element in vs2 and extend it to XLEN
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        bit_off   = '0;
        elem_bits = '0;
        elem_ok   = 1'b0;
        elem      = '0;
        case (sew_e'(bus.vsew_i))
            SEW_8:   bit_off = OFF_W'(bus.elem_idx_i) << 3;
            SEW_16:  bit_off = OFF_W'(bus.elem_idx_i) << 4;
            SEW_32:  bit_off = OFF_W'(bus.elem_idx_i) << 5;
            default: bit_off = '0;
        endcase
        elem_ok   = (sew_e'(bus.vsew_i) != SEW_RSV) && (bit_off < VLEN_BITS);
        elem_bits = 32'(bus.vs2_data_i >> bit_off);
        case (sew_e'(bus.vsew_i))
            SEW_8:   elem = bus.sign_ext_i ? XLEN'($signed(elem_bits[7:0]))
                                           : XLEN'(elem_bits[7:0]);
            SEW_16:  elem = bus.sign_ext_i ? XLEN'($signed(elem_bits[15:0]))
                                           : XLEN'(elem_bits[15:0]);
            SEW_32:  elem = bus.sign_ext_i ? XLEN'($signed(elem_bits))
                                           : XLEN'(elem_bits);
            default: elem = '0;
        endcase
        if (!elem_ok) begin
            elem = '0;
        end
    end

    // Result source select; flags travel with the result
    always_comb begin
        formed.result = '0;
        formed.flags  = bus.flags_i;
        case (src_e'(bus.src_i))
            SRC_VL:     formed.result = XLEN'(bus.vl_i);
            SRC_ELEM:   formed.result = elem;
            SRC_SCALAR: formed.result = bus.scalar_i;
            default:    formed.result = '0;
        endcase
    end

    // Issue when not held and something is queued; an empty, unheld queue
    // sends the new result straight to the output registers instead.
    assign full   = (count_r == DEPTH_CNT);
    assign pop    = !bus.hold_i && (count_r != '0);
    assign bypass = bus.push_i && !bus.hold_i && (count_r == '0);
    assign wr_en  = bus.push_i && !full && !bypass;
    assign drop   = bus.push_i && full;

    // Queue storage write
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; an entry is only ever read
        // after it has been written, and the pointers/count are reset.
        if (wr_en) begin
            mem[wr_ptr] <= formed;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every
        // flop samples values from before this edge.
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (drop) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output registers: one pulse per issued result, data held between pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_r <= 1'b0;
            out_r    <= '0;
        end else begin
            rvalid_r <= pop || bypass;
            if (pop) begin
                out_r <= mem[rd_ptr];
            end else if (bypass) begin
                out_r <= formed;
            end
        end
    end

    assign bus.apu_rvalid_o = rvalid_r;
    assign bus.apu_result_o = out_r.result;
    assign bus.apu_flags_o  = out_r.flags;
    assign bus.full_o       = full;
    assign bus.count_o      = count_r;
    assign bus.overflow_o   = overflow_r;
endmodule

// File: tb/tb_apu_result_queue.sv
// Self-checking bench for apu_result_queue: directed scenarios for bypass,
// element extraction, back-pressure, overflow and reset, followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_apu_result_queue;
    localparam int VLEN  = 128;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int VL_W  = $clog2(VLEN / 8) + 1;
    localparam int IDX_W = $clog2(VLEN / 8);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
    } ent_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    apu_result_queue_if #(
        .VLEN(VLEN), .XLEN(XLEN), .DEPTH(DEPTH),
        .VL_W(VL_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) bus ();

    apu_result_queue #(
        .VLEN(VLEN), .XLEN(XLEN), .DEPTH(DEPTH),
        .VL_W(VL_W), .IDX_W(IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    ent_t        q[$];
    logic        exp_valid;
    logic [31:0] exp_res;
    logic [4:0]  exp_fl;
    logic        exp_ovf;

    logic [127:0] vs2_pat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Result a committed instruction should return, from the source rules
    function automatic logic [31:0] ref_result(
        input logic [1:0] src, input logic [VL_W-1:0] vl, input logic [1:0] vsew,
        input logic [IDX_W-1:0] idx, input logic sext, input logic [127:0] vs2,
        input logic [31:0] scalar);
        int sew;
        int off;
        logic [127:0] mask;
        logic [127:0] e;
        if (src == 2'd0) return 32'(vl);
        if (src == 2'd2) return scalar;
        if (src == 2'd3) return 32'd0;
        if (vsew == 2'd3) return 32'd0;
        sew = 8 << vsew;
        off = int'(idx) * sew;
        if (off >= VLEN) return 32'd0;
        mask = (128'd1 << sew) - 128'd1;
        e = (vs2 >> off) & mask;
        if (sext && e[sew-1]) e = e | ~mask;
        return e[31:0];
    endfunction

    // Advance one clock: update the model from the current inputs, then
    // compare every output just after the edge.
    task automatic tick();
        ent_t f;
        ent_t h;
        logic was_full;
        f.res = ref_result(bus.src_i, bus.vl_i, bus.vsew_i, bus.elem_idx_i,
                           bus.sign_ext_i, bus.vs2_data_i, bus.scalar_i);
        f.fl  = bus.flags_i;
        if (reset) begin
            q.delete();
            exp_valid = 1'b0;
            exp_res   = '0;
            exp_fl    = '0;
            exp_ovf   = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            exp_valid = 1'b0;
            if (!bus.hold_i && q.size() > 0) begin
                h = q.pop_front();
                exp_res   = h.res;
                exp_fl    = h.fl;
                exp_valid = 1'b1;
            end
            if (bus.push_i) begin
                if (was_full) begin
                    exp_ovf = 1'b1;
                end else if (!bus.hold_i && !exp_valid) begin
                    exp_res   = f.res;
                    exp_fl    = f.fl;
                    exp_valid = 1'b1;
                end else begin
                    q.push_back(f);
                end
            end
        end
        @(posedge clk);
        #1;
        check("rvalid",   bus.apu_rvalid_o, exp_valid);
        check("result",   bus.apu_result_o, exp_res);
        check("flags",    bus.apu_flags_o,  exp_fl);
        check("count",    bus.count_o,      q.size());
        check("full",     bus.full_o,       q.size() == DEPTH);
        check("overflow", bus.overflow_o,   exp_ovf);
    endtask

    task automatic idle_inputs();
        bus.push_i     = 1'b0;
        bus.src_i      = 2'd0;
        bus.vl_i       = '0;
        bus.vsew_i     = 2'd0;
        bus.elem_idx_i = '0;
        bus.sign_ext_i = 1'b0;
        bus.vs2_data_i = '0;
        bus.scalar_i   = '0;
        bus.flags_i    = '0;
        bus.hold_i     = 1'b0;
    endtask

    task automatic push_scalar(input logic [31:0] val, input logic hold);
        bus.push_i   = 1'b1;
        bus.src_i    = 2'd2;
        bus.scalar_i = val;
        bus.flags_i  = val[4:0];
        bus.hold_i   = hold;
        tick();
    endtask

    initial begin
        idle_inputs();
        exp_valid = 1'b0;
        exp_res   = '0;
        exp_fl    = '0;
        exp_ovf   = 1'b0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Bypass of a VL result
        bus.push_i = 1'b1;
        bus.src_i  = 2'd0;
        bus.vl_i   = VL_W'(16);
        tick();
        check("bypass_vl_result", bus.apu_result_o, 32'h10);
        check("bypass_vl_valid",  bus.apu_rvalid_o, 1'b1);
        check("bypass_vl_count",  bus.count_o, 0);
        bus.push_i = 1'b0;
        tick();
        check("pulse_single", bus.apu_rvalid_o, 1'b0);

        // Byte element 3 with sign and zero extension
        vs2_pat = {$urandom(), $urandom(), $urandom(), $urandom()};
        vs2_pat[31:24] = 8'h80;
        bus.push_i     = 1'b1;
        bus.src_i      = 2'd1;
        bus.vs2_data_i = vs2_pat;
        bus.vsew_i     = 2'd0;
        bus.elem_idx_i = IDX_W'(3);
        bus.sign_ext_i = 1'b1;
        tick();
        check("elem8_sext", bus.apu_result_o, 32'hFFFFFF80);
        bus.sign_ext_i = 1'b0;
        tick();
        check("elem8_zext", bus.apu_result_o, 32'h00000080);

        // Top halfword element
        bus.vsew_i     = 2'd1;
        bus.elem_idx_i = IDX_W'(7);
        tick();
        check("elem16_top", bus.apu_result_o, 32'(vs2_pat[127:112]));

        // Out-of-range word element and reserved SEW
        bus.vsew_i     = 2'd2;
        bus.elem_idx_i = IDX_W'(4);
        tick();
        check("elem32_oob", bus.apu_result_o, 32'h0);
        bus.vsew_i     = 2'd0;
        bus.elem_idx_i = IDX_W'(1);
        tick();
        bus.vsew_i     = 2'd3;
        bus.elem_idx_i = IDX_W'(0);
        tick();
        check("elem_rsv_sew", bus.apu_result_o, 32'h0);
        bus.push_i = 1'b0;
        tick();

        // Back-pressure and overflow
        for (int i = 1; i <= 5; i++) begin
            push_scalar(32'(i), 1'b1);
            if (i == 4) check("full_after4", bus.full_o, 1'b1);
        end
        check("ovf_after5",   bus.overflow_o, 1'b1);
        check("count_after5", bus.count_o, 4);
        bus.push_i = 1'b0;
        bus.hold_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_valid", bus.apu_rvalid_o, 1'b1);
            check("drain_order", bus.apu_result_o, 32'(i));
        end
        tick();
        check("drain_empty", bus.count_o, 0);
        check("drain_done",  bus.apu_rvalid_o, 1'b0);

        // Simultaneous push and pop at occupancy two
        push_scalar(32'd10, 1'b1);
        push_scalar(32'd11, 1'b1);
        push_scalar(32'd12, 1'b0);
        check("pushpop_count",  bus.count_o, 2);
        check("pushpop_result", bus.apu_result_o, 32'd10);
        bus.push_i = 1'b0;
        tick();
        check("pushpop_next", bus.apu_result_o, 32'd11);
        tick();
        check("pushpop_last", bus.apu_result_o, 32'd12);
        tick();

        // Reset with three entries queued
        push_scalar(32'd21, 1'b1);
        push_scalar(32'd22, 1'b1);
        push_scalar(32'd23, 1'b1);
        bus.push_i = 1'b0;
        bus.hold_i = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_count",  bus.count_o, 0);
        check("rst_rvalid", bus.apu_rvalid_o, 1'b0);
        check("rst_ovf",    bus.overflow_o, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_no_rvalid", bus.apu_rvalid_o, 1'b0);
        end

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset          = ($urandom_range(0, 399) == 0);
            bus.push_i     = ($urandom_range(0, 99) < 60);
            bus.hold_i     = ($urandom_range(0, 99) < 35);
            bus.src_i      = 2'($urandom_range(0, 3));
            bus.vl_i       = VL_W'($urandom_range(0, 16));
            bus.vsew_i     = 2'($urandom_range(0, 3));
            bus.elem_idx_i = IDX_W'($urandom_range(0, 15));
            bus.sign_ext_i = 1'($urandom_range(0, 1));
            bus.vs2_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.scalar_i   = $urandom();
            bus.flags_i    = 5'($urandom_range(0, 31));
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
